// File: rtl/hilo_md_ctrl.sv
// HI/LO multiply/divide sequencer: 32-step shift-add multiply and restoring divide,
// plus mthi/mtlo moves, with registered one-cycle HI/LO write strobes.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for an EX-stage op; mthi/mtlo complete from here
// RUN   | one radix-2 multiply or divide step per cycle (32 steps)
// DONE  | write strobes visible this cycle; stalled instruction advances
module hilo_md_ctrl #(
    parameter logic [31:0] DIV0_LO = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        start,
    input  logic        op_div,
    input  logic        op_divu,
    input  logic        op_mult,
    input  logic        op_multu,
    input  logic        op_mthi,
    input  logic        op_mtlo,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    output logic        stall_req,
    output logic        busy,
    output logic        hi_we,
    output logic        lo_we,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;

    logic        is_div, is_md, is_signed;
    logic        accept, accept_md, accept_mthi, accept_mtlo, div0;
    logic        sign_a, sign_b;
    logic [31:0] mag_a, mag_b;

    logic [63:0] acc_q;
    logic [31:0] rem_q;
    logic [31:0] opb_q;
    logic [4:0]  cnt_q;
    logic        div_q, neg_q, sa_q;

    logic [32:0] mul_sum;
    logic [63:0] mul_nxt, prod_res;
    logic [32:0] shifted;
    logic        ge;
    logic [31:0] rem_nxt, quo_nxt, rem_res, quo_res;
    logic        last_step;

    logic        hi_we_d, lo_we_d, busy_d;
    logic [31:0] hi_d, lo_d;

    // Priority div > divu > mult > multu > mthi > mtlo falls out of the masking below.
    assign is_div      = op_div | op_divu;
    assign is_md       = is_div | op_mult | op_multu;
    assign is_signed   = op_div | (~op_divu & op_mult);
    assign accept      = start & (state_q == S_IDLE) & ~flush;
    assign accept_md   = accept & is_md;
    assign accept_mthi = accept & ~is_md & op_mthi;
    assign accept_mtlo = accept & ~is_md & ~op_mthi & op_mtlo;
    assign div0        = is_div & (src2 == 32'd0);

    // Magnitude of 0x80000000 is 2^31, which is exact as an unsigned 32-bit value.
    assign sign_a = is_signed & src1[31];
    assign sign_b = is_signed & src2[31];
    assign mag_a  = sign_a ? (~src1 + 32'd1) : src1;
    assign mag_b  = sign_b ? (~src2 + 32'd1) : src2;

    // Multiply step: {carry, hi} += multiplicand on multiplier LSB, then shift right.
    assign mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
    assign mul_nxt  = {mul_sum, acc_q[31:1]};
    assign prod_res = neg_q ? (~mul_nxt + 64'd1) : mul_nxt;

    // Divide step: 33-bit partial remainder, quotient shifts in through acc_q[31:0].
    assign shifted  = {rem_q, acc_q[31]};
    assign ge       = shifted >= {1'b0, opb_q};
    assign rem_nxt  = ge ? (shifted[31:0] - opb_q) : shifted[31:0];
    assign quo_nxt  = {acc_q[30:0], ge};
    assign quo_res  = neg_q ? (~quo_nxt + 32'd1) : quo_nxt;
    assign rem_res  = sa_q ? (~rem_nxt + 32'd1) : rem_nxt;

    assign last_step = (state_q == S_RUN) && (cnt_q == 5'd31);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: if (accept_md) state_d = div0 ? S_DONE : S_RUN;
                S_RUN:  if (cnt_q == 5'd31) state_d = S_DONE;
                S_DONE: state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        stall_req = ~rst & ~flush &
                    (((state_q == S_IDLE) & start & is_md) | (state_q == S_RUN));
        busy_d  = (state_d != S_IDLE);
        hi_we_d = 1'b0;
        lo_we_d = 1'b0;
        hi_d    = hi_o;
        lo_d    = lo_o;
        if (!flush) begin
            if (accept_mthi) begin
                hi_we_d = 1'b1;
                hi_d    = src1;
            end
            if (accept_mtlo) begin
                lo_we_d = 1'b1;
                lo_d    = src1;
            end
            if (accept_md && div0) begin
                hi_we_d = 1'b1;
                lo_we_d = 1'b1;
                hi_d    = src1;
                lo_d    = DIV0_LO;
            end
            if (last_step) begin
                hi_we_d = 1'b1;
                lo_we_d = 1'b1;
                hi_d    = div_q ? rem_res : prod_res[63:32];
                lo_d    = div_q ? quo_res : prod_res[31:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy  <= 1'b0;
            hi_we <= 1'b0;
            lo_we <= 1'b0;
            hi_o  <= 32'd0;
            lo_o  <= 32'd0;
        end else begin
            busy  <= busy_d;
            hi_we <= hi_we_d;
            lo_we <= lo_we_d;
            hi_o  <= hi_d;
            lo_o  <= lo_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= 64'd0;
            rem_q <= 32'd0;
            opb_q <= 32'd0;
            cnt_q <= 5'd0;
            div_q <= 1'b0;
            neg_q <= 1'b0;
            sa_q  <= 1'b0;
        end else if (accept_md) begin
            opb_q <= is_div ? mag_b : mag_a;
            acc_q <= {32'd0, (is_div ? mag_a : mag_b)};
            rem_q <= 32'd0;
            cnt_q <= 5'd0;
            div_q <= is_div;
            neg_q <= sign_a ^ sign_b;
            sa_q  <= sign_a;
        end else if (state_q == S_RUN) begin
            cnt_q <= cnt_q + 5'd1;
            acc_q <= div_q ? {32'd0, quo_nxt} : mul_nxt;
            rem_q <= rem_nxt;
        end
    end

endmodule

// File: tb/tb_hilo_md_ctrl.sv
// Bench for hilo_md_ctrl: vector table issued through a pipeline-like driver,
// write strobes checked against a scoreboard queue, plus flush/reset sequences.
module tb_hilo_md_ctrl;

    localparam logic [5:0] OP_DIV   = 6'b100000;
    localparam logic [5:0] OP_DIVU  = 6'b010000;
    localparam logic [5:0] OP_MULT  = 6'b001000;
    localparam logic [5:0] OP_MULTU = 6'b000100;
    localparam logic [5:0] OP_MTHI  = 6'b000010;
    localparam logic [5:0] OP_MTLO  = 6'b000001;

    logic        clk = 1'b0;
    logic        rst, flush, start;
    logic        op_div, op_divu, op_mult, op_multu, op_mthi, op_mtlo;
    logic [31:0] src1, src2;
    logic        stall_req, busy, hi_we, lo_we;
    logic [31:0] hi_o, lo_o;

    typedef struct {
        string       name;
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        ehw;
        logic        elw;
        logic [31:0] ehi;
        logic [31:0] elo;
        int          estall;
    } vec_t;

    typedef struct {
        string       name;
        logic        hw;
        logic        lw;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    vec_t vecs[$];
    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    hilo_md_ctrl dut (
        .clk(clk), .rst(rst), .flush(flush), .start(start),
        .op_div(op_div), .op_divu(op_divu), .op_mult(op_mult), .op_multu(op_multu),
        .op_mthi(op_mthi), .op_mtlo(op_mtlo), .src1(src1), .src2(src2),
        .stall_req(stall_req), .busy(busy), .hi_we(hi_we), .lo_we(lo_we),
        .hi_o(hi_o), .lo_o(lo_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input string nm, input logic [5:0] op, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
        vec_t v;
        v.name = nm; v.op = op; v.a = a; v.b = b; v.ehi = ehi; v.elo = elo;
        v.ehw = 1'b0; v.elw = 1'b0; v.estall = 0;
        if (|op[5:2]) begin
            v.ehw = 1'b1; v.elw = 1'b1;
            v.estall = ((|op[5:4]) && b == 32'd0) ? 1 : 33;
        end else if (op[1]) begin
            v.ehw = 1'b1;
        end else if (op[0]) begin
            v.elw = 1'b1;
        end
        return v;
    endfunction

    // Strobes are registered, so sampling on the falling edge is away from any update.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && (hi_we || lo_we)) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_write: hi_we=%b lo_we=%b hi_o=%h lo_o=%h", hi_we, lo_we, hi_o, lo_o);
            end else begin
                e = sb_q.pop_front();
                check({e.name, "_we"}, {30'd0, hi_we, lo_we}, {30'd0, e.hw, e.lw});
                if (e.hw) check({e.name, "_hi"}, hi_o, e.hi);
                if (e.lw) check({e.name, "_lo"}, lo_o, e.lo);
            end
        end
    end

    task automatic set_ops(input logic [5:0] op);
        {op_div, op_divu, op_mult, op_multu, op_mthi, op_mtlo} = op;
    endtask

    // Issue like the EX stage: hold the instruction while stall_req is high.
    task automatic issue(input vec_t v);
        exp_t e;
        int   cyc;
        @(negedge clk);
        if (v.ehw || v.elw) begin
            e.name = v.name; e.hw = v.ehw; e.lw = v.elw; e.hi = v.ehi; e.lo = v.elo;
            sb_q.push_back(e);
        end
        set_ops(v.op);
        src1  = v.a;
        src2  = v.b;
        start = 1'b1;
        #1;
        cyc = 0;
        while (stall_req && cyc < 40) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        check({v.name, "_stall_cycles"}, cyc, v.estall);
        if (v.estall > 0)
            check({v.name, "_strobe_cycle"}, {30'd0, hi_we, lo_we}, 32'd3);
    endtask

    task automatic idle();
        @(negedge clk);
        start = 1'b0;
        set_ops(6'd0);
    endtask

    initial begin
        logic signed [63:0] pa, pb, ps;
        logic [63:0]        pu;
        logic [31:0]        a, b;
        int                 sa, sb, kind, nw;
        vec_t               v;

        rst = 1'b1; flush = 1'b0; start = 1'b1; set_ops(OP_DIV);
        src1 = 32'd9; src2 = 32'd3;
        repeat (2) @(negedge clk);
        #1;
        check("rst_stall", {31'd0, stall_req}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_we", {30'd0, hi_we, lo_we}, 32'd0);
        check("rst_hi", hi_o, 32'd0);
        check("rst_lo", lo_o, 32'd0);
        @(negedge clk);
        start = 1'b0; set_ops(6'd0);
        rst = 1'b0;

        vecs.push_back(mk("div_m7_2",     OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD));
        vecs.push_back(mk("divu_big_16",  OP_DIVU,  32'hFFFF_FFFF, 32'h10,        32'h0000_000F, 32'h0FFF_FFFF));
        vecs.push_back(mk("mult_m2_3",    OP_MULT,  32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA));
        vecs.push_back(mk("multu_max",    OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001));
        vecs.push_back(mk("div_by0",      OP_DIV,   32'h1234,      32'd0,         32'h0000_1234, 32'hFFFF_FFFF));
        vecs.push_back(mk("div_ovf",      OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000));
        vecs.push_back(mk("mthi",         OP_MTHI,  32'hAAAA_5555, 32'd0,         32'hAAAA_5555, 32'd0));
        vecs.push_back(mk("mtlo",         OP_MTLO,  32'h5555_AAAA, 32'd0,         32'd0,         32'h5555_AAAA));
        vecs.push_back(mk("divu_by0",     OP_DIVU,  32'hDEAD_BEEF, 32'd0,         32'hDEAD_BEEF, 32'hFFFF_FFFF));
        vecs.push_back(mk("div_7_m2",     OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD));
        vecs.push_back(mk("mult_minsq",   OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0));
        vecs.push_back(mk("prio_div",     OP_DIV | OP_MULT, 32'd100, 32'd7,       32'd2,         32'd14));
        vecs.push_back(mk("prio_mult",    OP_MULT | OP_MTHI, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFB));
        vecs.push_back(mk("prio_mthi",    OP_MTHI | OP_MTLO, 32'h11, 32'd0,       32'h11,        32'd0));
        vecs.push_back(mk("no_op",        6'd0,     32'h5,         32'h6,         32'd0,         32'd0));
        for (int i = 0; i < 8; i++) begin
            kind = $urandom_range(0, 3);
            a = $urandom;
            b = $urandom;
            if (kind == 0) begin
                pa = {{32{a[31]}}, a};
                pb = {{32{b[31]}}, b};
                ps = pa * pb;
                v = mk("rnd_mult", OP_MULT, a, b, ps[63:32], ps[31:0]);
            end else if (kind == 1) begin
                pu = {32'd0, a} * {32'd0, b};
                v = mk("rnd_multu", OP_MULTU, a, b, pu[63:32], pu[31:0]);
            end else if (kind == 2) begin
                if (b == 32'd0) b = 32'd1;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd3;
                sa = a;
                sb = b;
                v = mk("rnd_div", OP_DIV, a, b, 32'(sa % sb), 32'(sa / sb));
            end else begin
                b = b >> $urandom_range(0, 31);
                if (b == 32'd0) b = 32'd1;
                v = mk("rnd_divu", OP_DIVU, a, b, a % b, a / b);
            end
            vecs.push_back(v);
        end

        foreach (vecs[i]) issue(vecs[i]);
        idle();

        // busy drops the cycle after DONE
        issue(mk("div_busy", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD));
        check("done_busy", {31'd0, busy}, 32'd1);
        idle();
        #1;
        check("after_done_busy", {31'd0, busy}, 32'd0);

        // flush in cycle 10 of a divide: no write ever
        @(negedge clk);
        set_ops(OP_DIV); src1 = 32'd100; src2 = 32'd7; start = 1'b1;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        #1;
        check("flush_stall", {31'd0, stall_req}, 32'd0);
        @(negedge clk);
        flush = 1'b0; start = 1'b0; set_ops(6'd0);
        #1;
        check("flush_busy", {31'd0, busy}, 32'd0);
        nw = 0;
        repeat (40) begin
            @(negedge clk);
            if (hi_we || lo_we) nw++;
        end
        check("flush_no_write", nw, 0);

        // flush on an mthi in IDLE suppresses the write
        @(negedge clk);
        set_ops(OP_MTHI); src1 = 32'h1357_9BDF; start = 1'b1; flush = 1'b1;
        #1;
        check("flush_mthi_stall", {31'd0, stall_req}, 32'd0);
        @(negedge clk);
        flush = 1'b0; start = 1'b0; set_ops(6'd0);
        #1;
        check("flush_mthi_we", {30'd0, hi_we, lo_we}, 32'd0);

        // reset mid-RUN clears everything immediately
        @(negedge clk);
        set_ops(OP_MULT); src1 = 32'd12; src2 = 32'd34; start = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_run_stall", {31'd0, stall_req}, 32'd0);
        check("rst_run_busy", {31'd0, busy}, 32'd0);
        check("rst_run_hi", hi_o, 32'd0);
        check("rst_run_lo", lo_o, 32'd0);
        @(negedge clk);
        start = 1'b0; set_ops(6'd0);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("rst_run_no_write", {30'd0, hi_we, lo_we}, 32'd0);

        // an operation after reset still works
        issue(mk("post_rst_mult", OP_MULT, 32'd12, 32'd34, 32'd0, 32'd408));
        idle();
        repeat (3) @(negedge clk);
        check("sb_drained", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
